// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: major opcodes, FSM states,
// ALU operation classes and writeback source selects.
package riscv_ctrl_pkg;

  localparam logic [6:0] OpcReg    = 7'b0110011;
  localparam logic [6:0] OpcImm    = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    AluAdd    = 2'b00,
    AluBranch = 2'b01,
    AluRtype  = 2'b10,
    AluItype  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    WbAlu  = 2'b00,
    WbMem  = 2'b01,
    WbPc4  = 2'b10,
    WbUimm = 2'b11
  } wb_sel_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder.
// Ports: inst (instruction word) -> alu_src, alu_op, sft, wb_sel, instruction class flags
// (is_load/is_store/is_branch/is_jump) and illegal (unsupported opcode or funct field).
module ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        sft,
  output logic [1:0]  wb_sel,
  output logic        is_load,
  output logic        is_store,
  output logic        is_branch,
  output logic        is_jump,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  always_comb begin
    alu_src   = 1'b0;
    alu_op    = AluAdd;
    sft       = 1'b0;
    wb_sel    = WbAlu;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OpcReg: begin
        alu_op  = AluRtype;
        illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OpcImm: begin
        alu_src = 1'b1;
        alu_op  = AluItype;
        sft     = (funct3 == 3'b001) || (funct3 == 3'b101);
      end
      OpcLoad: begin
        alu_src = 1'b1;
        wb_sel  = WbMem;
        is_load = 1'b1;
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OpcStore: begin
        alu_src  = 1'b1;
        is_store = 1'b1;
        illegal  = (funct3 >= 3'b011);
      end
      OpcBranch: begin
        alu_op    = AluBranch;
        is_branch = 1'b1;
      end
      OpcJal, OpcJalr: begin
        alu_src = 1'b1;
        wb_sel  = WbPc4;
        is_jump = 1'b1;
      end
      OpcLui: begin
        alu_src = 1'b1;
        wb_sel  = WbUimm;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, memory vs MMIO routing,
// wait-state handshake with timeout, sticky illegal/bus-error trapping into HALT.
// Ports: clk, rst_n (async active-low); inst, alu_result, mem_ready in; fetch/ir/pc strobes,
// memory/IO read/write strobes with size/sign, regfile write, ALU controls, branch/jump,
// sticky illegal and bus_err out.
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN    = 32,
  parameter logic [XLEN-1:0] IO_BASE = 32'hFFFF_FC00,
  parameter logic [XLEN-1:0] IO_MASK = 32'hFFFF_FC00,
  parameter int unsigned     TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] alu_result,
  input  logic            mem_ready,
  output logic            fetch_req,
  output logic            ir_we,
  output logic            pc_we,
  output logic            mem_read,
  output logic            mem_write,
  output logic            io_read,
  output logic            io_write,
  output logic [1:0]      mem_size,
  output logic            mem_unsigned,
  output logic            reg_write,
  output logic [1:0]      wb_sel,
  output logic            alu_src,
  output logic [1:0]      alu_op,
  output logic            sft,
  output logic            branch,
  output logic            jump,
  output logic [2:0]      branch_type,
  output logic            illegal,
  output logic            bus_err
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            is_io_q, is_io_d;
  logic            illegal_q, illegal_d;
  logic            bus_err_q, bus_err_d;

  logic       dec_alu_src, dec_sft, dec_is_load, dec_is_store, dec_is_branch, dec_is_jump;
  logic       dec_illegal;
  logic [1:0] dec_alu_op, dec_wb_sel;

  ctrl_decode u_decode (
    .inst      (inst),
    .alu_src   (dec_alu_src),
    .alu_op    (dec_alu_op),
    .sft       (dec_sft),
    .wb_sel    (dec_wb_sel),
    .is_load   (dec_is_load),
    .is_store  (dec_is_store),
    .is_branch (dec_is_branch),
    .is_jump   (dec_is_jump),
    .illegal   (dec_illegal)
  );

  logic addr_is_io, misalign, timeout_hit;

  assign addr_is_io  = (alu_result & IO_MASK) == (IO_BASE & IO_MASK);
  assign misalign    = ((inst[13:12] == 2'b01) && alu_result[0]) ||
                       ((inst[13:12] == 2'b10) && (alu_result[1:0] != 2'b00));
  // Expiry cycle: counter has reached TIMEOUT; mem_ready in this cycle still completes.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      cnt_q     <= '0;
      is_io_q   <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_io_q   <= is_io_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_io_d      = is_io_q;
    illegal_d    = illegal_q;
    bus_err_d    = bus_err_q;
    fetch_req    = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    io_read      = 1'b0;
    io_write     = 1'b0;
    mem_size     = 2'b00;
    mem_unsigned = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 2'b00;
    alu_src      = 1'b0;
    alu_op       = 2'b00;
    sft          = 1'b0;
    branch       = 1'b0;
    jump         = 1'b0;
    branch_type  = 3'b000;

    unique case (state_q)
      StFetch: begin
        fetch_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          state_d   = StHalt;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDecode: begin
        if (dec_illegal) begin
          illegal_d = 1'b1;
          state_d   = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        alu_src     = dec_alu_src;
        alu_op      = dec_alu_op;
        sft         = dec_sft;
        branch      = dec_is_branch;
        jump        = dec_is_jump;
        branch_type = dec_is_branch ? inst[14:12] : 3'b000;
        if (dec_is_branch) begin
          pc_we   = 1'b1;
          cnt_d   = '0;
          state_d = StFetch;
        end else if (dec_is_load || dec_is_store) begin
          is_io_d = addr_is_io;
          if (misalign) begin
            bus_err_d = 1'b1;
            state_d   = StHalt;
          end else begin
            cnt_d   = '0;
            state_d = StMem;
          end
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        mem_size     = inst[13:12];
        mem_unsigned = inst[14];
        mem_read     = dec_is_load && !is_io_q;
        io_read      = dec_is_load && is_io_q;
        mem_write    = dec_is_store && !is_io_q;
        io_write     = dec_is_store && is_io_q;
        if (mem_ready) begin
          if (dec_is_store) begin
            pc_we   = 1'b1;
            cnt_d   = '0;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          state_d   = StHalt;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWb: begin
        reg_write = (inst[11:7] != 5'd0);
        pc_we     = 1'b1;
        wb_sel    = dec_wb_sel;
        // Load data extension is applied on the writeback path.
        if (dec_is_load) begin
          mem_size     = inst[13:12];
          mem_unsigned = inst[14];
        end
        cnt_d   = '0;
        state_d = StFetch;
      end
      StHalt: ;
      default: state_d = StHalt;
    endcase

    // State register already holds FETCH during reset; keep every strobe quiet until release.
    if (!rst_n) begin
      fetch_req    = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      io_read      = 1'b0;
      io_write     = 1'b0;
      mem_size     = 2'b00;
      mem_unsigned = 1'b0;
      reg_write    = 1'b0;
      wb_sel       = 2'b00;
      alu_src      = 1'b0;
      alu_op       = 2'b00;
      sft          = 1'b0;
      branch       = 1'b0;
      jump         = 1'b0;
      branch_type  = 3'b000;
    end
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

endmodule
